// File: rtl/mmio_uart_tx_if.sv
// rtl/mmio_uart_tx_if.sv - MMIO access bundle between the memory stage (master) and the UART transmitter (slave)
interface mmio_uart_tx_if;
  logic        mmio_w_enable;
  logic [31:0] mmio_addr;
  logic [31:0] mmio_w_data;
  logic [31:0] mmio_r_data;
  logic        mmio_write_complete;

  modport master (
    output mmio_w_enable, mmio_addr, mmio_w_data,
    input  mmio_r_data, mmio_write_complete
  );

  modport slave (
    input  mmio_w_enable, mmio_addr, mmio_w_data,
    output mmio_r_data, mmio_write_complete
  );
endinterface

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - MMIO UART transmitter: TXDATA/STATUS registers, byte FIFO, 8N1 serialiser
// Optional even-parity bit after the data bits when MMIO_UART_PARITY_EN is defined.
module mmio_uart_tx #(
  parameter logic [31:0] mmio_base_addr = 32'h00030000,
  parameter int          clocks_per_bit = 16,
  parameter int          fifo_depth     = 4
) (
  input  logic          clock,
  input  logic          reset,
  mmio_uart_tx_if.slave bus,
  output logic          tx
);
  localparam int PW = $clog2(fifo_depth);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(clocks_per_bit);
  localparam logic [CW-1:0] FULL_COUNT  = CW'(fifo_depth);
  localparam logic [BW-1:0] BAUD_LAST   = BW'(clocks_per_bit - 1);
  localparam logic [31:0]   STATUS_ADDR = mmio_base_addr + 32'd4;

`ifdef MMIO_UART_PARITY_EN
  localparam logic PARITY_FLAG = 1'b1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  localparam logic PARITY_FLAG = 1'b0;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state, state_n;
  logic [7:0]    mem [fifo_depth];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [7:0]    data_reg, data_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0]    bit_idx, bit_n;
  logic          tx_n;
  logic          fifo_full, fifo_empty;
  logic          sel_txdata, sel_status;
  logic          push, pop;
  logic          unused_bits;

  assign sel_txdata = bus.mmio_addr[31:2] == mmio_base_addr[31:2];
  assign sel_status = bus.mmio_addr[31:2] == STATUS_ADDR[31:2];
  assign fifo_full  = count == FULL_COUNT;
  assign fifo_empty = count == '0;
  assign unused_bits = ^{bus.mmio_w_data[31:8], bus.mmio_addr[1:0]};

  // Uses the pre-edge full flag, so a pop on the same edge cannot admit a push.
  assign bus.mmio_write_complete = reset && bus.mmio_w_enable && !(sel_txdata && fifo_full);
  assign push = bus.mmio_write_complete && sel_txdata;

  always_comb begin
    state_n = state;
    tx_n    = tx;
    data_n  = data_reg;
    baud_n  = baud;
    bit_n   = bit_idx;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        tx_n   = 1'b1;
        baud_n = '0;
        bit_n  = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          data_n  = mem[rd_ptr];
          state_n = START;
          tx_n    = 1'b0;
        end
      end
      START: begin
        baud_n = baud + 1'b1;
        if (baud == BAUD_LAST) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = DATA;
          tx_n    = data_reg[0];
        end
      end
      DATA: begin
        baud_n = baud + 1'b1;
        if (baud == BAUD_LAST) begin
          baud_n = '0;
          bit_n  = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
            state_n = PARITY;
            tx_n    = ^data_reg;
`else
            state_n = STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            tx_n = data_reg[bit_idx + 3'd1];
          end
        end
      end
`ifdef MMIO_UART_PARITY_EN
      PARITY: begin
        baud_n = baud + 1'b1;
        if (baud == BAUD_LAST) begin
          baud_n  = '0;
          state_n = STOP;
          tx_n    = 1'b1;
        end
      end
`endif
      STOP: begin
        baud_n = baud + 1'b1;
        if (baud == BAUD_LAST) begin
          baud_n = '0;
          // Back-to-back frames: the next start bit follows the stop bit directly.
          if (!fifo_empty) begin
            pop     = 1'b1;
            data_n  = mem[rd_ptr];
            state_n = START;
            tx_n    = 1'b0;
          end else begin
            state_n = IDLE;
            tx_n    = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      data_reg <= '0;
      baud     <= '0;
      bit_idx  <= '0;
    end else begin
      state    <= state_n;
      tx       <= tx_n;
      data_reg <= data_n;
      baud     <= baud_n;
      bit_idx  <= bit_n;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= bus.mmio_w_data[7:0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.mmio_r_data <= '0;
    end else if (sel_status) begin
      bus.mmio_r_data <= {16'h0000, 8'(count), 4'h0, PARITY_FLAG, fifo_empty, fifo_full, state != IDLE};
    end else begin
      bus.mmio_r_data <= '0;
    end
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - bench for mmio_uart_tx: per-cycle line/queue model plus hand-computed frames
module tb_mmio_uart_tx;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h00030000;
  localparam logic [31:0] STAT  = BASE + 32'd4;
`ifdef MMIO_UART_PARITY_EN
  localparam int               NBITS = 11;
  localparam logic             PAR   = 1'b1;
  localparam logic [NBITS-1:0] F55   = 11'h4AA;
  localparam logic [NBITS-1:0] F07   = 11'h60E;
`else
  localparam int               NBITS = 10;
  localparam logic             PAR   = 1'b0;
  localparam logic [NBITS-1:0] F55   = 10'h2AA;
  localparam logic [NBITS-1:0] F07   = 10'h20E;
`endif

  typedef struct packed {
    logic lvl;
    logic first;
  } slot_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic tx;
  int   total = 0;
  int   bad = 0;

  // Line model: one entry per future clock of tx level; m_count = bytes queued but not started.
  slot_t       line_q[$];
  int          m_count = 0;
  logic        m_busy = 1'b0;
  logic        m_tx = 1'b1;
  logic [31:0] m_rdata = '0;

  mmio_uart_tx_if bus();

  mmio_uart_tx #(
    .mmio_base_addr(BASE),
    .clocks_per_bit(CPB),
    .fifo_depth(DEPTH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus),
    .tx(tx)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit hits(input logic [31:0] a, input logic [31:0] r);
    return a[31:2] == r[31:2];
  endfunction

  function automatic logic model_complete();
    return reset && bus.mmio_w_enable && !(hits(bus.mmio_addr, BASE) && m_count >= DEPTH);
  endfunction

  function automatic void append_frame(input logic [7:0] d);
    logic lv;
    for (int b = 0; b < NBITS; b++) begin
      if (b == 0) lv = 1'b0;
      else if (b <= 8) lv = d[b-1];
      else if (PAR && b == 9) lv = ^d;
      else lv = 1'b1;
      for (int c = 0; c < CPB; c++) line_q.push_back({lv, (b == 0 && c == 0)});
    end
  endfunction

  always @(posedge clock or negedge reset) begin : model
    logic [31:0] rd;
    bit          accept;
    logic [7:0]  wd;
    slot_t       s;
    if (!reset) begin
      line_q.delete();
      m_count = 0;
      m_busy  = 1'b0;
      m_tx    = 1'b1;
      m_rdata = '0;
    end else begin
      rd = '0;
      if (hits(bus.mmio_addr, STAT)) begin
        rd[0]    = m_busy;
        rd[1]    = (m_count == DEPTH);
        rd[2]    = (m_count == 0);
        rd[3]    = PAR;
        rd[15:8] = 8'(m_count);
      end
      accept = model_complete() && hits(bus.mmio_addr, BASE);
      wd = bus.mmio_w_data[7:0];
      if (line_q.size() > 0) begin
        s = line_q.pop_front();
        m_tx = s.lvl;
        m_busy = 1'b1;
        if (s.first) m_count--;
      end else begin
        m_tx = 1'b1;
        m_busy = 1'b0;
      end
      if (accept) begin
        m_count++;
        append_frame(wd);
      end
      m_rdata = rd;
    end
  end

  always @(negedge clock) begin
    check("tx", {31'd0, tx}, {31'd0, m_tx});
    check("complete", {31'd0, bus.mmio_write_complete}, {31'd0, model_complete()});
    check("r_data", bus.mmio_r_data, m_rdata);
  end

  task automatic mmio_write(input logic [31:0] a, input logic [31:0] d, output int waited);
    bus.mmio_w_enable = 1'b1;
    bus.mmio_addr = a;
    bus.mmio_w_data = d;
    waited = 0;
    @(negedge clock);
    while (!bus.mmio_write_complete && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    if (waited >= 200) begin
      total++;
      bad++;
      $display("FAIL write_timeout: complete never rose for addr 0x%08h", a);
    end
    @(posedge clock);
    #2;
    bus.mmio_w_enable = 1'b0;
  endtask

  task automatic read_reg(input logic [31:0] a, output logic [31:0] v);
    bus.mmio_addr = a;
    @(posedge clock);
    #2;
    v = bus.mmio_r_data;
  endtask

  task automatic wait_idle(input string name);
    logic [31:0] v;
    int n;
    n = 0;
    do begin
      read_reg(STAT, v);
      n++;
    end while ((v[0] || !v[2]) && n < 1000);
    total++;
    if (n >= 1000) begin
      bad++;
      $display("FAIL %s_idle_timeout: status 0x%08h never went idle", name, v);
    end
  endtask

  task automatic check_frame(input string name, input logic [NBITS-1:0] exp);
    logic [NBITS-1:0] got;
    bit steady;
    steady = 1'b1;
    got = '0;
    bus.mmio_addr = STAT;
    @(negedge clock);
    check({name, "_pre"}, {31'd0, tx}, 32'd1);
    for (int b = 0; b < NBITS; b++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge clock);
        if (c == 0) got[b] = tx;
        else if (tx !== got[b]) steady = 1'b0;
      end
    end
    check({name, "_bits"}, 32'(got), 32'(exp));
    check({name, "_steady"}, {31'd0, steady}, 32'd1);
    @(negedge clock);
    check({name, "_post"}, {31'd0, tx}, 32'd1);
    @(posedge clock);
    #2;
  endtask

  initial begin
    int          w;
    logic [31:0] rd;
    bit          saw_low;

    bus.mmio_w_enable = 1'b1;
    bus.mmio_addr = BASE;
    bus.mmio_w_data = 32'h0000_00AA;
    @(negedge clock);
    check("rst_complete", {31'd0, bus.mmio_write_complete}, 32'd0);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_rdata", bus.mmio_r_data, 32'd0);
    @(posedge clock);
    #2;
    reset = 1'b1;
    bus.mmio_w_enable = 1'b0;
    read_reg(STAT, rd);
    check("idle_status", rd, {28'd0, PAR, 3'b100});

    // single 0x55 frame, upper data bits ignored
    mmio_write(BASE, 32'hABCD_EF55, w);
    check("w55_wait", w, 0);
    check_frame("f55", F55);
    read_reg(STAT, rd);
    read_reg(STAT, rd);
    check("f55_idle", rd, {28'd0, PAR, 3'b100});

    // five writes absorb without stall, the sixth waits for the first pop
    wait_idle("burst");
    for (int i = 0; i < 5; i++) begin
      mmio_write(BASE, 32'h10 + i, w);
      check($sformatf("burst_wait%0d", i), w, 0);
    end
    mmio_write(BASE, 32'h20, w);
    check("burst_stall", w, NBITS * CPB - 3);

    // three queued behind an active frame, then an unmapped write
    wait_idle("queue");
    for (int i = 0; i < 4; i++) mmio_write(BASE, 32'h31 + i, w);
    read_reg(STAT, rd);
    check("status_301", rd, 32'h0000_0301 | {28'd0, PAR, 3'd0});
    mmio_write(BASE + 32'd8, 32'hFF, w);
    check("unmapped_wait", w, 0);
    read_reg(STAT, rd);
    check("unmapped_count", rd, 32'h0000_0301 | {28'd0, PAR, 3'd0});
    read_reg(BASE + 32'd8, rd);
    check("unmapped_read", rd, 32'd0);
    mmio_write(STAT, 32'h77, w);
    check("status_write_wait", w, 0);
    read_reg(BASE, rd);
    check("txdata_read", rd, 32'd0);
    read_reg(STAT, rd);
    check("status_write_count", rd, 32'h0000_0301 | {28'd0, PAR, 3'd0});

    wait_idle("f07");
    mmio_write(BASE, 32'h07, w);
    check_frame("f07", F07);

    // reset mid-frame aborts and leaves nothing queued
    wait_idle("abort");
    mmio_write(BASE, 32'h00, w);
    repeat (12) @(posedge clock);
    #3;
    check("abort_pre_tx", {31'd0, tx}, 32'd0);
    reset = 1'b0;
    #1;
    check("abort_tx", {31'd0, tx}, 32'd1);
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b1;
    read_reg(STAT, rd);
    check("abort_status", rd, {28'd0, PAR, 3'b100});
    saw_low = 1'b0;
    repeat (60) begin
      @(negedge clock);
      if (!tx) saw_low = 1'b1;
    end
    @(posedge clock);
    #2;
    check("abort_no_frame", {31'd0, saw_low}, 32'd0);

    repeat (5) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the hart's MMIO bus, downstream of the memory-transaction stage.
- Consumes the MMIO write control that the memory stage drives.
- Returns read data and a write-complete handshake, so stage 4 can stall on a full transmit queue.
- Buffers bytes in a small FIFO and serialises them 8N1 onto a single tx line.

Parameters:
- mmio_base_addr, 32'h00030000: word-aligned base address. TXDATA is at base+0, STATUS at base+4.
- clocks_per_bit, 16: clock cycles per serial bit. Must be ≥2.
- fifo_depth, 4: transmit FIFO entries. Power of two, ≥2.

Ports:
- clock  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- mmio_w_enable  input  1  access strobe from memory stage; held high until mmio_write_complete.
- mmio_addr  input  32  byte address. Decoded on addr[31:2] against base and base+4.
- mmio_w_data  input  32  write value. Only bits [7:0] are used; width is ignored.
- mmio_r_data  output  32  registered read data, one-cycle latency.
- mmio_write_complete  output  1  combinational; the write is accepted on the clock edge where this is high.
- tx  output  1  serial line, idles high.

Behaviour:
Reset (reset=0, asynchronous):
- tx=1, mmio_r_data=0, FIFO emptied, FSM=IDLE, bit/baud counters=0.
- mmio_write_complete=0 while in reset.
- Reset asserted mid-frame aborts the frame immediately: tx returns high with no stop bit.

Write handshake (mmio_write_complete):
- Targeting TXDATA: complete = w_enable && !fifo_full. Push of w_data[7:0] occurs on that edge.
- Targeting any other address (incl. STATUS): complete = w_enable. The write is ignored.
- FIFO full: complete stays 0 until a pop frees a slot. complete is computed from the current, pre-edge full flag, so a pop on the same edge does not admit a push that cycle.

Read data (mmio_r_data):
- Captured each edge from the current mmio_addr.
- STATUS layout:
  - bit0 busy (FSM != IDLE)
  - bit1 fifo_full
  - bit2 fifo_empty
  - bits[15:8] fifo count, zero-extended
  - all other bits 0
- TXDATA and unmapped addresses read 0.

FIFO:
- Circular buffer with read/write pointers wrapping modulo fifo_depth, plus a count of width clog2(fifo_depth)+1.
- Simultaneous push and pop (not full, not empty): count unchanged.
- Pop only from IDLE or at the end of STOP.

FSM, states IDLE, START, DATA, STOP:
- IDLE: tx=1. If FIFO non-empty: pop into shift register, go to START, tx=0 from that edge.
- START: hold tx=0 for clocks_per_bit cycles, then DATA with tx=shift[0].
- DATA: each bit lasts clocks_per_bit cycles, LSB first, 8 bits. After bit 7, go to STOP with tx=1.
- STOP: tx=1 for clocks_per_bit cycles. Then, if FIFO non-empty, pop and go directly to START (no idle gap); else go to IDLE.

Timing and counters:
- Push on edge E0 produces the start-bit falling edge on E1.
- Frame length is exactly 10*clocks_per_bit cycles.
- Baud counter counts 0..clocks_per_bit-1 and wraps; the bit index wraps 0..7.

Optional Feature:
- Macro: MMIO_UART_PARITY_EN.
- Defined: an even-parity bit (XOR of the 8 data bits) is sent after bit 7 in a PARITY state lasting clocks_per_bit cycles. Frame = 11*clocks_per_bit. STATUS bit3 reads 1.
- Undefined: no PARITY state, frame = 10*clocks_per_bit, STATUS bit3 reads 0.

Test Plan:
- clocks_per_bit=4: write 0x55 to base+0 at idle → complete high that cycle. One edge later tx=0 for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then 1 for 4 cycles. busy=1 throughout, then 0.
- Write 5 bytes back-to-back, fifo_depth=4, w_enable held:
  - the first byte is popped into the shifter immediately, so up to 5 are accepted without a stall;
  - a 6th write has complete=0 until the first frame's STOP ends, then completes.
  - Frames on tx are contiguous with no idle gap.
- Read base+4 with 3 bytes queued and a frame active → next cycle mmio_r_data=0x00000301 (count=3, busy=1, neither full nor empty).
- Write to base+8 → complete=1 the same cycle, FIFO count unchanged, the following read of base+8 returns 0.
- Pull reset low mid-DATA on a 0x00 frame → tx=1 asynchronously. After release: FSM IDLE, STATUS=0x00000004, FIFO empty, and no frame is emitted.
- MMIO_UART_PARITY_EN defined, write 0x07 → parity bit 1 after bit 7, frame = 11*clocks_per_bit cycles.
